spi_slave_wide: RTL and testbench

Parametrised SPI slave, successor to the fixed 8-bit mode-0 slave used on the miner's host link. It adds a configurable word width, all four CPOL/CPHA modes, MSB- or LSB-first ordering, and a buffered transmit path with a valid/ready handshake and underrun reporting. It sits between the external SPI pins, already at the FPGA boundary, and the command/response logic in the `clk` domain.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave_wide.sv | 152 +++++++++++++++
 tb/tb_spi_slave_wide.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and helpers for the wide SPI slave.
// Mode encoding is {CPOL, CPHA}.
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_SYNC_STAGES_DEF = 2;

    // Never returns less than 1, so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, followed by a registered edge
// detector. level, rise and fall all appear STAGES+1 cycles after the pin changes.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_wide.sv
// SPI slave with configurable word width, CPOL/CPHA mode and bit order, and a
// single-entry TX holding register with valid/ready handshake and underrun flag.
module spi_slave_wide
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ssel,
    output logic              miso,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int unsigned       CNT_W = clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]        MODE  = {CPOL, CPHA};

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d_i(sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .rst_n(rst_n), .d_i(ssel),
        .level_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall, ssel_rise};

    logic lead_e, trail_e, sample_e, shift_e, selected, load_e, accept;

    assign lead_e   = (MODE == SPI_MODE0 || MODE == SPI_MODE1) ? sck_rise : sck_fall;
    assign trail_e  = (MODE == SPI_MODE0 || MODE == SPI_MODE1) ? sck_fall : sck_rise;
    assign sample_e = CPHA ? trail_e : lead_e;
    assign shift_e  = CPHA ? lead_e : trail_e;
    assign selected = ~ssel_lvl;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              und_q, und_d;

    // Shift edges only arrive with cnt_q==0 once a word has wrapped, so the
    // same test covers CPHA=0 word boundaries and the CPHA=1 first edge.
    assign load_e = selected & (((CPHA == 1'b0) & ssel_fall) | (shift_e & (cnt_q == '0)));
    assign accept = tx_valid & ~hold_full_q;

    always_comb begin
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        und_d       = 1'b0;

        if (!selected) begin
            cnt_d   = '0;
            rx_sh_d = '0;
            tx_sh_d = '0;
        end else begin
            if (sample_e) begin
                rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_lvl}
                                    : {mosi_lvl, rx_sh_q[DATA_W-1:1]};
                if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (load_e) begin
                if (hold_full_q) begin
                    tx_sh_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    tx_sh_d = '0;
                    und_d   = 1'b1;
                end
            end else if (shift_e) begin
                tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_sh_q[DATA_W-1:1]};
            end
        end

        // Applied after the word load so the old entry is consumed first.
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            und_q       <= und_d;
        end
    end

    assign miso        = selected & (MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0]);
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = und_q;
    assign busy        = selected;

endmodule

// File: tb/tb_spi_slave_wide.sv
// Directed bench for spi_slave_wide: four instances covering modes 0-3, widths
// 8/12/16 and both bit orders, sharing sck/mosi with one select line each.
module tb_spi_slave_wide;

    logic clk = 1'b0;
    logic rst_n;
    logic sck, mosi;
    logic ssel0, ssel1, ssel2, ssel3;

    logic        miso0, rxv0, txv0, txr0, und0_o, busy0;
    logic [7:0]  rxd0, txd0;
    logic        miso1, rxv1, txv1, txr1, und1_o, busy1;
    logic [11:0] rxd1, txd1;
    logic        miso2, rxv2, txv2, txr2, und2_o, busy2;
    logic [11:0] rxd2, txd2;
    logic        miso3, rxv3, txv3, txr3, und3_o, busy3;
    logic [15:0] rxd3, txd3;

    always #5 clk = ~clk;

    spi_slave_wide #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel0), .miso(miso0),
        .rx_valid(rxv0), .rx_data(rxd0), .tx_valid(txv0), .tx_ready(txr0),
        .tx_data(txd0), .tx_underrun(und0_o), .busy(busy0));
    spi_slave_wide #(.DATA_W(12), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel1), .miso(miso1),
        .rx_valid(rxv1), .rx_data(rxd1), .tx_valid(txv1), .tx_ready(txr1),
        .tx_data(txd1), .tx_underrun(und1_o), .busy(busy1));
    spi_slave_wide #(.DATA_W(12), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel2), .miso(miso2),
        .rx_valid(rxv2), .rx_data(rxd2), .tx_valid(txv2), .tx_ready(txr2),
        .tx_data(txd2), .tx_underrun(und2_o), .busy(busy2));
    spi_slave_wide #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel3), .miso(miso3),
        .rx_valid(rxv3), .rx_data(rxd3), .tx_valid(txv3), .tx_ready(txr3),
        .tx_data(txd3), .tx_underrun(und3_o), .busy(busy3));

    int total = 0;
    int passed = 0;
    int nfail = 0;
    int und0 = 0, und1 = 0, und2 = 0, und3 = 0;
    logic [63:0] q0[$], q1[$], q2[$], q3[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rx_valid pops the word the master sent for that slave.
    always @(negedge clk) begin
        if (rxv0) begin
            chk("rx0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) chk("rx0_data", 64'(rxd0), q0.pop_front());
        end
        if (rxv1) begin
            chk("rx1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) chk("rx1_data", 64'(rxd1), q1.pop_front());
        end
        if (rxv2) begin
            chk("rx2_expected", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) chk("rx2_data", 64'(rxd2), q2.pop_front());
        end
        if (rxv3) begin
            chk("rx3_expected", 64'(q3.size() != 0), 64'd1);
            if (q3.size() != 0) chk("rx3_data", 64'(rxd3), q3.pop_front());
        end
        if (und0_o) und0++;
        if (und1_o) und1++;
        if (und2_o) und2++;
        if (und3_o) und3++;
    end

    function automatic logic miso_of(input int inst);
        case (inst)
            0: return miso0;
            1: return miso1;
            2: return miso2;
            default: return miso3;
        endcase
    endfunction

    function automatic logic ready_of(input int inst);
        case (inst)
            0: return txr0;
            1: return txr1;
            2: return txr2;
            default: return txr3;
        endcase
    endfunction

    task automatic set_ssel(input int inst, input logic v);
        case (inst)
            0: ssel0 = v;
            1: ssel1 = v;
            2: ssel2 = v;
            default: ssel3 = v;
        endcase
    endtask

    task automatic drive_tx(input int inst, input logic v, input logic [63:0] d);
        case (inst)
            0: begin txv0 = v; txd0 = d[7:0]; end
            1: begin txv1 = v; txd1 = d[11:0]; end
            2: begin txv2 = v; txd2 = d[11:0]; end
            default: begin txv3 = v; txd3 = d[15:0]; end
        endcase
    endtask

    task automatic wait_h();
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_push(input int inst, input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_of(inst) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", 64'(ready_of(inst)), 64'd1);
        drive_tx(inst, 1'b1, d);
        @(negedge clk);
        drive_tx(inst, 1'b0, 64'd0);
        chk("tx_ready_drop", 64'(ready_of(inst)), 64'd0);
    endtask

    task automatic select(input int inst, input logic cpol);
        sck = cpol;
        wait_h();
        set_ssel(inst, 1'b0);
        wait_h();
        wait_h();
    endtask

    task automatic deselect(input int inst);
        wait_h();
        set_ssel(inst, 1'b1);
        wait_h();
        wait_h();
    endtask

    // Master side: drives nbits of word and collects what the slave returns.
    task automatic xfer(input int inst, input int w, input logic cpol, input logic cpha,
                        input logic msb, input logic [63:0] word, input int nbits,
                        output logic [63:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi = word[b];
                wait_h();
                sck = ~cpol;
                got[b] = miso_of(inst);
                wait_h();
                sck = cpol;
            end else begin
                wait_h();
                sck = ~cpol;
                mosi = word[b];
                wait_h();
                sck = cpol;
                got[b] = miso_of(inst);
            end
        end
    endtask

    initial begin
        logic [63:0] got;
        rst_n = 1'b0;
        sck = 1'b0;
        mosi = 1'b0;
        ssel0 = 1'b1; ssel1 = 1'b1; ssel2 = 1'b1; ssel3 = 1'b1;
        txv0 = 1'b0; txv1 = 1'b0; txv2 = 1'b0; txv3 = 1'b0;
        txd0 = '0; txd1 = '0; txd2 = '0; txd3 = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_miso", 64'(miso0), 64'd0);
        chk("rst_rx_valid", 64'(rxv0), 64'd0);
        chk("rst_rx_data", 64'(rxd0), 64'd0);
        chk("rst_tx_ready", 64'(txr0), 64'd1);
        chk("rst_underrun", 64'(und0_o), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);

        // Mode 0, 8-bit MSB first.
        tx_push(0, 64'h3C);
        select(0, 1'b0);
        chk("t1_busy", 64'(busy0), 64'd1);
        chk("t1_hold_consumed", 64'(txr0), 64'd1);
        q0.push_back(64'hA5);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 64'hA5, 8, got);
        chk("t1_master_rx", got, 64'h3C);
        deselect(0);
        chk("t1_busy_off", 64'(busy0), 64'd0);
        chk("t1_tail_underrun", 64'(und0), 64'd1);

        // Mode 3, 16-bit LSB first, two-word burst.
        tx_push(3, 64'hCAFE);
        select(3, 1'b1);
        q3.push_back(64'h1234);
        q3.push_back(64'hBEEF);
        xfer(3, 16, 1'b1, 1'b1, 1'b0, 64'h1234, 16, got);
        chk("t2_word1", got, 64'hCAFE);
        tx_push(3, 64'h5A5A);
        xfer(3, 16, 1'b1, 1'b1, 1'b0, 64'hBEEF, 16, got);
        chk("t2_word2", got, 64'h5A5A);
        deselect(3);
        chk("t2_no_underrun", 64'(und3), 64'd0);

        // Modes 1 and 2, 12-bit loopback.
        tx_push(1, 64'hABC);
        select(1, 1'b0);
        q1.push_back(64'hABC);
        xfer(1, 12, 1'b0, 1'b1, 1'b1, 64'hABC, 12, got);
        chk("t3_mode1", got, 64'hABC);
        deselect(1);
        chk("t3_mode1_und", 64'(und1), 64'd0);
        tx_push(2, 64'hABC);
        select(2, 1'b1);
        q2.push_back(64'hABC);
        xfer(2, 12, 1'b1, 1'b0, 1'b1, 64'hABC, 12, got);
        chk("t3_mode2", got, 64'hABC);
        deselect(2);
        chk("t3_mode2_und", 64'(und2), 64'd1);

        // Underrun on the second word of a burst, recovery on the third.
        tx_push(1, 64'h111);
        select(1, 1'b0);
        q1.push_back(64'h123);
        q1.push_back(64'h456);
        q1.push_back(64'h789);
        xfer(1, 12, 1'b0, 1'b1, 1'b1, 64'h123, 12, got);
        chk("t4_word1", got, 64'h111);
        xfer(1, 12, 1'b0, 1'b1, 1'b1, 64'h456, 12, got);
        chk("t4_word2_zero", got, 64'h000);
        chk("t4_underrun", 64'(und1), 64'd1);
        tx_push(1, 64'h7E7);
        xfer(1, 12, 1'b0, 1'b1, 1'b1, 64'h789, 12, got);
        chk("t4_word3", got, 64'h7E7);
        deselect(1);
        chk("t4_underrun_once", 64'(und1), 64'd1);

        // Partial word discarded, then a clean frame.
        select(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 64'hFF, 5, got);
        deselect(0);
        chk("t5_rx_data_held", 64'(rxd0), 64'hA5);
        chk("t5_sel_underrun", 64'(und0), 64'd2);
        tx_push(0, 64'h99);
        select(0, 1'b0);
        q0.push_back(64'h5A);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 64'h5A, 8, got);
        chk("t5_master_rx", got, 64'h99);
        deselect(0);
        chk("t5_rx_data", 64'(rxd0), 64'h5A);

        // Asynchronous reset in the middle of a word.
        tx_push(0, 64'hFF);
        select(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 64'h00, 4, got);
        tx_push(0, 64'h42);
        chk("t6_pre_miso", 64'(miso0), 64'd1);
        chk("t6_pre_busy", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_miso", 64'(miso0), 64'd0);
        chk("t6_rx_valid", 64'(rxv0), 64'd0);
        chk("t6_rx_data", 64'(rxd0), 64'd0);
        chk("t6_tx_ready", 64'(txr0), 64'd1);
        chk("t6_underrun", 64'(und0_o), 64'd0);
        chk("t6_busy", 64'(busy0), 64'd0);
        ssel0 = 1'b1;
        sck = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
